cla_arb2: RTL and testbench

CLA_ARB2 -- requirements
Module: cla_arb2

---
 rtl/cla_arb_pkg.sv | 30 +++
 rtl/cla_8bit_ovf_uvf.sv | 47 ++++
 rtl/cla_arb2.sv | 186 ++++++++++++++++++
 tb/tb_cla_arb2.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_arb_pkg.sv
// cla_arb_pkg -- shared types and constants for the two-requester adder arbiter.
//   state_e    : arbiter FSM states (IDLE, CALC, RESP)
//   operand_t  : 8-bit signed two's-complement operand/result type
//   SAT_MAX/SAT_MIN : clamp values used when saturation is built in (CLA_SAT_EN)
//   CNT_MAX    : ceiling of the overflow/underflow event counters
package cla_arb_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] operand_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam operand_t   SAT_MAX = operand_t'(8'h7F);
    localparam operand_t   SAT_MIN = operand_t'(8'h80);
    localparam logic [7:0] CNT_MAX = 8'd255;

    // Event counter step that sticks at CNT_MAX instead of wrapping.
    function automatic logic [7:0] cnt_inc(logic [7:0] cnt, logic ev);
        if (cnt == CNT_MAX) begin
            return cnt;
        end
        return cnt + {7'd0, ev};
    endfunction

endpackage

// File: rtl/cla_8bit_ovf_uvf.sv
// cla_8bit_ovf_uvf -- 8-bit signed carry-lookahead adder with signed
// overflow/underflow detection. Purely combinational.
//   a, b : signed operands
//   sum  : 8-bit wrapped sum
//   ovf  : pos + pos produced a negative sum
//   uvf  : neg + neg produced a non-negative sum
module cla_8bit_ovf_uvf
    import cla_arb_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum,
    output logic                     ovf,
    output logic                     uvf
);

    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is formed directly from generate/propagate terms (flat
    // lookahead), not chained from the previous carry.
    always_comb begin
        logic acc;
        logic prop;
        acc  = 1'b0;
        prop = 1'b0;
        c    = '0;
        for (int i = 0; i < DATA_W - 1; i++) begin
            acc  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = acc;
        end
    end

    assign sum = p ^ c;
    assign ovf = ~a[DATA_W-1] & ~b[DATA_W-1] &  sum[DATA_W-1];
    assign uvf =  a[DATA_W-1] &  b[DATA_W-1] & ~sum[DATA_W-1];

endmodule

// File: rtl/cla_arb2.sv
// cla_arb2 -- round-robin arbiter sharing one signed CLA adder between two
// requesters. One operation every three cycles at best: accept (IDLE),
// compute (CALC), hold result until consumed (RESP).
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqN_valid/reqN_ready : operand handshake per requester (N = 0, 1)
//   reqN_a, reqN_b        : signed 8-bit operands
//   rsp_valid/rsp_ready   : result handshake
//   rsp_id                : requester owning the result
//   rsp_sum               : signed result
//   rsp_ovf/rsp_uvf       : signed overflow / underflow of this result
//   ovf_cnt/uvf_cnt       : saturating counts of overflow / underflow results
// Parameter FIRST_GRANT: requester winning the first contended grant after reset.
// Build option CLA_SAT_EN: clamp rsp_sum to +127/-128 on overflow/underflow.
module cla_arb2
    import cla_arb_pkg::*;
#(
    parameter int FIRST_GRANT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_sum,
    output logic       rsp_ovf,
    output logic       rsp_uvf,
    output logic [7:0] ovf_cnt,
    output logic [7:0] uvf_cnt
);

    localparam logic FG = (FIRST_GRANT != 0);

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    operand_t   op_a_q, op_a_d;
    operand_t   op_b_q, op_b_d;
    logic       op_id_q, op_id_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    operand_t   rsp_sum_q, rsp_sum_d;
    logic       rsp_ovf_q, rsp_ovf_d;
    logic       rsp_uvf_q, rsp_uvf_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0] uvf_cnt_q, uvf_cnt_d;

    logic       gnt_id;
    logic       idle;
    operand_t   add_sum;
    operand_t   sum_fmt;
    logic       add_ovf;
    logic       add_uvf;

`ifdef CLA_SAT_EN
    function automatic operand_t sat_sum(operand_t s, logic o, logic u);
        operand_t r;
        if (o) begin
            r = SAT_MAX;
        end else if (u) begin
            r = SAT_MIN;
        end else begin
            r = s;
        end
        return r;
    endfunction
`endif

    cla_8bit_ovf_uvf u_add (
        .a   (op_a_q),
        .b   (op_b_q),
        .sum (add_sum),
        .ovf (add_ovf),
        .uvf (add_uvf)
    );

`ifdef CLA_SAT_EN
    assign sum_fmt = sat_sum(add_sum, add_ovf, add_uvf);
`else
    assign sum_fmt = add_sum;
`endif

    // Contention goes to the requester not served last; otherwise to
    // whichever one is asking.
    assign gnt_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign idle   = (state_q == ST_IDLE);

    // Gated by rst_n so ready is low for the whole reset window, not just
    // from the first edge.
    assign req0_ready = rst_n && idle && req0_valid && !gnt_id;
    assign req1_ready = rst_n && idle && req1_valid &&  gnt_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_uvf_d    = rsp_uvf_q;
        ovf_cnt_d    = ovf_cnt_q;
        uvf_cnt_d    = uvf_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_ready || req1_ready) begin
                    op_a_d       = gnt_id ? operand_t'(req1_a) : operand_t'(req0_a);
                    op_b_d       = gnt_id ? operand_t'(req1_b) : operand_t'(req0_b);
                    op_id_d      = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = ST_CALC;
                end
            end
            ST_CALC: begin
                rsp_sum_d   = sum_fmt;
                rsp_ovf_d   = add_ovf;
                rsp_uvf_d   = add_uvf;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                ovf_cnt_d   = cnt_inc(ovf_cnt_q, add_ovf);
                uvf_cnt_d   = cnt_inc(uvf_cnt_q, add_uvf);
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Return to IDLE only; a new accept waits for the next cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ~FG;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_uvf_q    <= 1'b0;
            ovf_cnt_q    <= '0;
            uvf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_uvf_q    <= rsp_uvf_d;
            ovf_cnt_q    <= ovf_cnt_d;
            uvf_cnt_q    <= uvf_cnt_d;
        end
    end

    // Operand capture: pure data, only meaningful once loaded on accept.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_uvf   = rsp_uvf_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign uvf_cnt   = uvf_cnt_q;

endmodule

// File: tb/tb_cla_arb2.sv
// tb_cla_arb2 -- scoreboard bench for cla_arb2 (FIRST_GRANT = 0).
// Expected results are pushed when a handshake is seen; a monitor pops and
// compares whenever a result is consumed. Honors CLA_SAT_EN like the design.
module tb_cla_arb2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [7:0] rsp_sum;
    logic       rsp_ovf, rsp_uvf;
    logic [7:0] ovf_cnt, uvf_cnt;

    always #5 clk = ~clk;

    cla_arb2 #(.FIRST_GRANT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_ovf    (rsp_ovf),
        .rsp_uvf    (rsp_uvf),
        .ovf_cnt    (ovf_cnt),
        .uvf_cnt    (uvf_cnt)
    );

    typedef struct {
        logic       id;
        logic [7:0] sum;
        logic       ovf;
        logic       uvf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] got_q[$];
    int         checks = 0;
    int         fails  = 0;
    logic       last_m;
    int         ocnt_m, ucnt_m;
    logic       h0, h1;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Reference: exact integer sum, then classify and fold into 8 bits.
    function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   s;
        s     = int'($signed(a)) + int'($signed(b));
        e.id  = id;
        e.ovf = (s > 127);
        e.uvf = (s < -128);
`ifdef CLA_SAT_EN
        if (e.ovf)      e.sum = 8'h7F;
        else if (e.uvf) e.sum = 8'h80;
        else            e.sum = s[7:0];
`else
        e.sum = s[7:0];
`endif
        return e;
    endfunction

    function automatic logic [7:0] rnd8();
        logic [7:0] edges [4];
        edges[0] = 8'h7F; edges[1] = 8'h80; edges[2] = 8'hFF; edges[3] = 8'h01;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    // Monitor: every consumed result must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp: actual sum %0d id %0d, required no response", rsp_sum, rsp_id);
            end else begin
                mon_e = exp_q.pop_front();
                ocnt_m = (ocnt_m < 255) ? ocnt_m + int'(mon_e.ovf) : 255;
                ucnt_m = (ucnt_m < 255) ? ucnt_m + int'(mon_e.uvf) : 255;
                chk("rsp_id",  32'(rsp_id),  32'(mon_e.id));
                chk("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                chk("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
                chk("rsp_uvf", 32'(rsp_uvf), 32'(mon_e.uvf));
                chk("ovf_cnt", 32'(ovf_cnt), 32'(ocnt_m));
                chk("uvf_cnt", 32'(uvf_cnt), 32'(ucnt_m));
                got_q.push_back(rsp_sum);
            end
        end
    end

    // One clock of stimulus; reports which requester (if any) handshook.
    task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic rr, output logic hs0, output logic hs1);
        logic want;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        @(negedge clk);
        hs0 = v0 && req0_ready;
        hs1 = v1 && req1_ready;
        chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        if (exp_q.size() != 0)
            chk("ready_while_busy", 32'({req0_ready, req1_ready}), 32'd0);
        if (hs0 || hs1) begin
            want = (v0 && v1) ? ~last_m : v1;
            chk("grant_id", 32'(hs1), 32'(want));
            last_m = hs1;
            exp_q.push_back(model(hs1, hs1 ? a1 : a0, hs1 ? b1 : b0));
        end
    endtask

    task automatic idle_step(input logic rr);
        logic x0, x1;
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, rr, x0, x1);
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) idle_step(1'b1);
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL rsp_timeout: actual %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b);
        logic x0, x1, hs;
        hs = 1'b0;
        for (int k = 0; k < 8 && !hs; k++) begin
            step(!id, a, b, id, a, b, 1'b1, x0, x1);
            hs = x0 | x1;
        end
        if (!hs) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: actual 0 required 1");
        end
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready",     32'({req0_ready, req1_ready}), 32'd0);
        chk("rst_flags",     32'({rsp_ovf, rsp_uvf}), 32'd0);
        chk("rst_sum_id",    32'({rsp_sum, rsp_id}), 32'd0);
        chk("rst_counters",  32'({ovf_cnt, uvf_cnt}), 32'd0);
        exp_q.delete();
        last_m = 1'b1;
        ocnt_m = 0;
        ucnt_m = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic p0, p1;
        logic [7:0] a0, b0, a1, b1;

        do_reset();

        // 127 + 1 from req0: rsp_valid appears two cycles after the accept cycle.
        step(1'b1, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, h0, h1);
        chk("lat_accept", 32'(h0), 32'd1);
        idle_step(1'b1);
        chk("lat_calc_valid", 32'(rsp_valid), 32'd0);
        idle_step(1'b1);
        chk("lat_resp_valid", 32'(rsp_valid), 32'd1);
        chk("lat_ovf_cnt", 32'(ovf_cnt), 32'd1);
        drain();

        // -128 + -1 from req1.
        run_op(1'b1, 8'h80, 8'hFF);
        chk("uvf_cnt_one", 32'(uvf_cnt), 32'd1);

        // Both valid continuously from reset: 15 (id0), -7 (id1), 15 (id0).
        do_reset();
        got_q.delete();
        for (int k = 0; k < 12; k++)
            step(1'b1, 8'd10, 8'd5, 1'b1, 8'hFD, 8'hFC, 1'b1, h0, h1);
        drain();
        chk("rr_count", 32'(got_q.size() >= 3), 32'd1);
        if (got_q.size() >= 3) begin
            chk("rr_first",  32'(got_q[0]), 32'd15);
            chk("rr_second", 32'(got_q[1]), 32'hF9);
            chk("rr_third",  32'(got_q[2]), 32'd15);
        end

        // Back-pressure: result 20 held for 5 cycles while both requesters wait.
        got_q.delete();
        step(1'b1, 8'd10, 8'd10, 1'b0, 8'h00, 8'h00, 1'b0, h0, h1);
        chk("stall_accept", 32'(h0), 32'd1);
        idle_step(1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8'd1, 8'd1, 1'b1, 8'd2, 8'd2, 1'b0, h0, h1);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_hold",  32'({rsp_sum, rsp_id, rsp_ovf, rsp_uvf}), 32'({8'd20, 3'b000}));
            chk("stall_no_hs", 32'({h0, h1}), 32'd0);
        end
        idle_step(1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        chk("stall_single", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("stall_sum", 32'(got_q[0]), 32'd20);

        // Reset while a result waits in RESP: dropped, counters cleared.
        step(1'b1, 8'd100, 8'd100, 1'b0, 8'h00, 8'h00, 1'b0, h0, h1);
        idle_step(1'b0);
        idle_step(1'b0);
        chk("drop_pending", 32'(rsp_valid), 32'd1);
        chk("drop_cnt_before", 32'(ovf_cnt), 32'd1);
        do_reset();
        got_q.delete();
        step(1'b1, 8'd3, 8'd4, 1'b1, 8'd5, 8'd6, 1'b1, h0, h1);
        chk("post_rst_grant", 32'({h0, h1}), 32'b10);
        drain();
        chk("post_rst_single", 32'(got_q.size()), 32'd1);

        // Counter saturation.
        do_reset();
        for (int k = 0; k < 300; k++) run_op(1'b0, 8'd100, 8'd100);
        chk("ovf_cnt_sat", 32'(ovf_cnt), 32'd255);
        chk("uvf_cnt_zero", 32'(uvf_cnt), 32'd0);

        // Random traffic: valid is sticky until accepted, operands may wander.
        do_reset();
        p0 = 1'b0;
        p1 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!p0 && $urandom_range(0, 2) == 0) p0 = 1'b1;
            if (!p1 && $urandom_range(0, 2) == 0) p1 = 1'b1;
            a0 = rnd8(); b0 = rnd8(); a1 = rnd8(); b1 = rnd8();
            step(p0, a0, b0, p1, a1, b1, ($urandom_range(0, 3) != 0), h0, h1);
            if (h0) p0 = 1'b0;
            if (h1) p1 = 1'b0;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
